mux_rr_stream: RTL and testbench

MUX_RR_STREAM -- requirements
Module: mux_rr_stream

---
 rtl/mux_rr_stream.sv | 111 +++++++++++
 tb/tb_mux_rr_stream.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mux_rr_stream.sv
// mux_rr_stream: CHANNELS-way valid/ready stream multiplexer with a
// registered output stage and a round-robin arbiter.
//
// Build option: define MUX_RR_FIXPRIO_EN to replace the round-robin
// arbiter with fixed priority (lowest valid index wins, no pointer).
// Interface, latency and handshake are the same in both builds.
//
// Ports:
//   CLK        clock, all state on the rising edge
//   RST_N      asynchronous active-low reset
//   IN_DATA    CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   IN_VALID   per-channel beat offered
//   IN_READY   per-channel beat accepted this cycle (one-hot or zero)
//   OUT_DATA   registered selected beat
//   OUT_VALID  OUT_DATA holds a beat
//   OUT_READY  downstream accepts the beat
//   OUT_SEL    channel index the OUT_DATA beat came from
module mux_rr_stream #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned SELW    = $clog2(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
    input  logic [CHANNELS-1:0]       IN_VALID,
    output logic [CHANNELS-1:0]       IN_READY,
    output logic [WIDTH-1:0]          OUT_DATA,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [SELW-1:0]           OUT_SEL
);

    logic            load;
    logic            grant_any;
    logic [SELW-1:0] grant_idx;
    logic [SELW-1:0] search_start;
    logic [SELW-1:0] idx;
    logic [WIDTH-1:0] grant_data;

    // Output register can take a new beat when empty or being drained.
    assign load = !OUT_VALID || OUT_READY;

`ifdef MUX_RR_FIXPRIO_EN
    assign search_start = '0;
`else
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_next;

    assign ptr_next = (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr <= '0;
        end else if (load && grant_any) begin
            ptr <= ptr_next;
        end
    end

    assign search_start = ptr;
`endif

    // Scan from the search start upward with wrap; first valid channel wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            idx = SELW'((32'(search_start) + k) % CHANNELS);
            if (!grant_any && IN_VALID[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (grant_idx == SELW'(k)) begin
                grant_data = IN_DATA[k*WIDTH +: WIDTH];
            end
        end
    end

    // RST_N gates the ready so nothing is accepted while reset is held.
    always_comb begin
        IN_READY = '0;
        if (RST_N && load && grant_any) begin
            IN_READY[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_SEL   <= '0;
        end else if (load) begin
            if (grant_any) begin
                OUT_VALID <= 1'b1;
                OUT_DATA  <= grant_data;
                OUT_SEL   <= grant_idx;
            end else begin
                // Drained with nothing to replace it: data/sel keep last beat.
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb_mux_rr_stream: directed self-checking bench for mux_rr_stream
// (WIDTH=8, CHANNELS=4). Inputs change just after the falling edge;
// combinational IN_READY is checked 1ns later, registered outputs are
// checked on the following falling edge.
module tb_mux_rr_stream;

    logic        CLK;
    logic        RST_N;
    logic [31:0] IN_DATA;
    logic [3:0]  IN_VALID;
    logic [3:0]  IN_READY;
    logic [7:0]  OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [1:0]  OUT_SEL;

    int unsigned n_cmp;
    int unsigned n_err;

    mux_rr_stream #(
        .WIDTH    (8),
        .CHANNELS (4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_SEL   (OUT_SEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs just after a falling edge and check the granted ready.
    task automatic drive(input logic [3:0] v, input logic r, input logic [3:0] exp_rdy, input string tag);
        IN_VALID  = v;
        OUT_READY = r;
        #1;
        check_val(tag, 64'(IN_READY), 64'(exp_rdy));
    endtask

    // Cross one rising edge and check the registered outputs.
    task automatic next_out(input logic exp_v, input logic [1:0] exp_sel, input logic [7:0] exp_data, input string tag);
        @(negedge CLK);
        check_val({tag, ".valid"}, 64'(OUT_VALID), 64'(exp_v));
        check_val({tag, ".sel"},   64'(OUT_SEL),   64'(exp_sel));
        check_val({tag, ".data"},  64'(OUT_DATA),  64'(exp_data));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 4; i++) IN_DATA[i*8 +: 8] = 8'hA0 + 8'(i);
        RST_N     = 1'b0;
        IN_VALID  = 4'b1111;
        OUT_READY = 1'b1;

        // Reset state, including no acceptance while reset is held.
        @(negedge CLK);
        check_val("rst.valid", 64'(OUT_VALID), 64'd0);
        check_val("rst.data",  64'(OUT_DATA),  64'd0);
        check_val("rst.sel",   64'(OUT_SEL),   64'd0);
        check_val("rst.ready", 64'(IN_READY),  64'd0);
        @(negedge CLK);
        RST_N = 1'b1;

`ifdef MUX_RR_FIXPRIO_EN
        // Fixed priority: channel 1 always beats channel 3.
        for (int i = 0; i < 5; i++) begin
            drive(4'b1010, 1'b1, 4'b0010, "fix.rdy");
            next_out(1'b1, 2'd1, 8'hA1, "fix.out");
        end
`else
        // All channels valid: grants rotate 0,1,2,3,0,1 one per cycle.
        for (int i = 0; i < 6; i++) begin
            drive(4'b1111, 1'b1, 4'(1 << (i % 4)), "rr.rdy");
            next_out(1'b1, 2'(i % 4), 8'hA0 + 8'(i % 4), "rr.out");
        end

        // Stall 3 cycles holding channel 1's beat; resume with channel 2.
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 1'b0, 4'b0000, "stall.rdy");
            next_out(1'b1, 2'd1, 8'hA1, "stall.out");
        end
        drive(4'b1111, 1'b1, 4'b0100, "resume.rdy");
        next_out(1'b1, 2'd2, 8'hA2, "resume.out");

        // Grant channel 3, then only channel 0 valid wraps; pointer then at 1.
        drive(4'b1000, 1'b1, 4'b1000, "last3.rdy");
        next_out(1'b1, 2'd3, 8'hA3, "last3.out");
        drive(4'b0001, 1'b1, 4'b0001, "wrap.rdy");
        next_out(1'b1, 2'd0, 8'hA0, "wrap.out");
        drive(4'b1111, 1'b1, 4'b0010, "ptr1.rdy");
        next_out(1'b1, 2'd1, 8'hA1, "ptr1.out");

        // Single-cycle offer on channel 2, then drain with hold of data/sel.
        drive(4'b0100, 1'b1, 4'b0100, "single.rdy");
        next_out(1'b1, 2'd2, 8'hA2, "single.out");
        drive(4'b0000, 1'b1, 4'b0000, "idle.rdy");
        next_out(1'b0, 2'd2, 8'hA2, "idle.out");

        // Idle cycle did not move pointer (at 3): 0111 picks channel 0.
        drive(4'b0111, 1'b1, 4'b0001, "hold.rdy");
        next_out(1'b1, 2'd0, 8'hA0, "hold.out");

        // Asynchronous reset between edges discards the held beat.
        IN_VALID = 4'b1111;
        #2;
        RST_N = 1'b0;
        #1;
        check_val("arst.valid", 64'(OUT_VALID), 64'd0);
        check_val("arst.data",  64'(OUT_DATA),  64'd0);
        check_val("arst.sel",   64'(OUT_SEL),   64'd0);
        check_val("arst.ready", 64'(IN_READY),  64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        drive(4'b1110, 1'b1, 4'b0010, "post.rdy1");
        next_out(1'b1, 2'd1, 8'hA1, "post.out1");
        RST_N = 1'b0;
        #1;
        @(negedge CLK);
        RST_N = 1'b1;
        drive(4'b1111, 1'b1, 4'b0001, "post.rdy0");
        next_out(1'b1, 2'd0, 8'hA0, "post.out0");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
